// File: rtl/general_register_writeback.sv
// Write-side front end for the GPR file: request FIFO, 8/16/32-bit merge, full-width write port.
// Optional define GPR_WRITEBACK_FORWARD_EN bypasses the in-flight write into the merge base.
module general_register_writeback #(
  parameter int DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_index,
  input  logic [1:0]  req_size,
  input  logic        req_high,
  input  logic [31:0] req_data,
  input  logic        hold,
  input  logic [31:0] EAX,
  input  logic [31:0] EBX,
  input  logic [31:0] ECX,
  input  logic [31:0] EDX,
  input  logic [31:0] ESI,
  input  logic [31:0] EDI,
  input  logic [31:0] EBP,
  input  logic [31:0] ESP,
  output logic        write_enable,
  output logic [2:0]  write_index,
  output logic [31:0] write_data,
  output logic        error,
  output logic        busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_WORD    = 2'b01;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [2:0]  index;
    logic [1:0]  size;
    logic        high;
    logic [31:0] data;
  } entry_t;

  entry_t           fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  entry_t      head;
  logic        push;
  logic        pop;
  logic        stall;
  logic        fwd_hit;
  logic        illegal;
  logic [31:0] base;
  logic [31:0] merged;

  assign req_ready = (count != CNT_W'(DEPTH));
  assign busy      = (count != '0) || write_enable;
  assign head      = fifo_mem[rd_ptr];
  assign push      = req_valid && req_ready;
  assign pop       = (count != '0) && !hold && !stall;
  assign fwd_hit   = write_enable && (write_index == head.index);

  // The write in flight has not reached the register file yet, so its value
  // is either bypassed into the base or the pop waits one cycle for it.
  always_comb begin
    case (head.index)
      3'd0:    base = EAX;
      3'd1:    base = EBX;
      3'd2:    base = ECX;
      3'd3:    base = EDX;
      3'd4:    base = ESI;
      3'd5:    base = EDI;
      3'd6:    base = EBP;
      default: base = ESP;
    endcase
`ifdef GPR_WRITEBACK_FORWARD_EN
    stall = 1'b0;
    if (fwd_hit) base = write_data;
`else
    stall = fwd_hit;
`endif
  end

  always_comb begin
    merged  = head.data;
    illegal = (head.size == SIZE_ILLEGAL) ||
              ((head.size == SIZE_BYTE) && head.high && head.index[2]);
    case (head.size)
      SIZE_BYTE: merged = head.high ? {base[31:16], head.data[7:0], base[7:0]}
                                    : {base[31:8], head.data[7:0]};
      SIZE_WORD: merged = {base[31:16], head.data[15:0]};
      default:   merged = head.data;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= '{index: req_index, size: req_size, high: req_high, data: req_data};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Index and data hold their last value; only the strobes are single-cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_index  <= '0;
      write_data   <= '0;
      error        <= 1'b0;
    end else begin
      write_enable <= 1'b0;
      error        <= 1'b0;
      if (pop) begin
        if (illegal) begin
          error <= 1'b1;
        end else begin
          write_enable <= 1'b1;
          write_index  <= head.index;
          write_data   <= merged;
        end
      end
    end
  end

endmodule

// File: tb/tb_general_register_writeback.sv
// Bench for general_register_writeback: vector table, directed corner sequences, and random
// traffic scored against a queue-plus-architectural-register model with a local register file.
`timescale 1ns/1ps
module tb_general_register_writeback;

  localparam int DEPTH = 2;
`ifdef GPR_WRITEBACK_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam logic [1:0] BYTE = 2'b00, WORD = 2'b01, DWORD = 2'b10, ILL = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_index;
  logic [1:0]  req_size;
  logic        req_high;
  logic [31:0] req_data;
  logic        hold;
  logic        write_enable;
  logic [2:0]  write_index;
  logic [31:0] write_data;
  logic        error;
  logic        busy;

  logic [31:0] regs [8];
  logic        preload_en;
  logic [2:0]  preload_idx;
  logic [31:0] preload_val;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] seen[$];
  int          err_seen;

  typedef struct {
    logic [2:0]  idx;
    logic [1:0]  size;
    logic        high;
    logic [31:0] data;
    logic [31:0] base;
    logic        exp_we;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  idx;
    logic [1:0]  size;
    logic        high;
    logic [31:0] data;
  } req_t;

  vec_t vecs [10];

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (preload_en) regs[preload_idx] <= preload_val;
    else if (write_enable) regs[write_index] <= write_data;
  end

  general_register_writeback #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_size(req_size), .req_high(req_high), .req_data(req_data),
    .hold(hold),
    .EAX(regs[0]), .EBX(regs[1]), .ECX(regs[2]), .EDX(regs[3]),
    .ESI(regs[4]), .EDI(regs[5]), .EBP(regs[6]), .ESP(regs[7]),
    .write_enable(write_enable), .write_index(write_index), .write_data(write_data),
    .error(error), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] idx, input logic [1:0] sz,
                               input logic hi, input logic [31:0] d, input logic h);
    req_valid = v;
    req_index = idx;
    req_size  = sz;
    req_high  = hi;
    req_data  = d;
    hold      = h;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic tickRecord();
    tick();
    if (write_enable) seen.push_back(write_data);
    if (error) err_seen++;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [31:0] val);
    @(negedge clock);
    preload_en  = 1'b1;
    preload_idx = idx;
    preload_val = val;
    tick();
    preload_en  = 1'b0;
  endtask

  function automatic logic [31:0] modelMerge(input logic [31:0] b, input req_t r);
    case (r.size)
      BYTE:    return r.high ? ((b & 32'hFFFF00FF) | ((r.data & 32'hFF) << 8))
                             : ((b & 32'hFFFFFF00) | (r.data & 32'hFF));
      WORD:    return (b & 32'hFFFF0000) | (r.data & 32'hFFFF);
      default: return r.data;
    endcase
  endfunction

  function automatic bit modelIllegal(input req_t r);
    return (r.size == ILL) || (r.size == BYTE && r.high && r.idx >= 3'd4);
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: run did not finish within time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] arch [8];
    req_t        mq[$];
    req_t        h;
    req_t        r;
    logic        m_we, m_err;
    logic [2:0]  m_idx;
    logic [31:0] m_data;
    bit          do_pop, do_push, exp_ready;
    int          gap;

    vecs[0] = '{3'd0, BYTE,  1'b0, 32'hFFFFFF5A, 32'h11223344, 1'b1, 32'h1122335A, 1'b0};
    vecs[1] = '{3'd1, BYTE,  1'b1, 32'h00000077, 32'hAABBCCDD, 1'b1, 32'hAABB77DD, 1'b0};
    vecs[2] = '{3'd3, WORD,  1'b0, 32'hABCD5678, 32'hDEADBEEF, 1'b1, 32'hDEAD5678, 1'b0};
    vecs[3] = '{3'd7, DWORD, 1'b0, 32'hCAFEF00D, 32'h01020304, 1'b1, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{3'd4, BYTE,  1'b0, 32'h00000099, 32'h55667788, 1'b1, 32'h55667799, 1'b0};
    vecs[5] = '{3'd5, BYTE,  1'b1, 32'h00000011, 32'h12345678, 1'b0, 32'h0,        1'b1};
    vecs[6] = '{3'd0, ILL,   1'b0, 32'h00000000, 32'h00000000, 1'b0, 32'h0,        1'b1};
    vecs[7] = '{3'd3, BYTE,  1'b1, 32'h00000042, 32'h00000000, 1'b1, 32'h00004200, 1'b0};
    vecs[8] = '{3'd6, WORD,  1'b0, 32'h0000BEEF, 32'hFFFFFFFF, 1'b1, 32'hFFFFBEEF, 1'b0};
    vecs[9] = '{3'd2, BYTE,  1'b1, 32'h000000C3, 32'h0000FFFF, 1'b1, 32'h0000C3FF, 1'b0};

    preload_en = 1'b0; preload_idx = '0; preload_val = '0;
    reset = 1'b1;
    applyStimulus(1'b0, 3'd0, BYTE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 8; i++) preload(3'(i), 32'h0);
    checkOutput("reset_we",    32'(write_enable), 32'h0);
    checkOutput("reset_idx",   32'(write_index),  32'h0);
    checkOutput("reset_data",  write_data,        32'h0);
    checkOutput("reset_err",   32'(error),        32'h0);
    checkOutput("reset_busy",  32'(busy),         32'h0);
    checkOutput("reset_ready", 32'(req_ready),    32'h1);
    @(negedge clock);
    reset = 1'b0;

    // Single isolated requests from the vector table.
    for (int v = 0; v < 10; v++) begin
      preload(vecs[v].idx, vecs[v].base);
      @(negedge clock);
      applyStimulus(1'b1, vecs[v].idx, vecs[v].size, vecs[v].high, vecs[v].data, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_we_early", v), 32'(write_enable), 32'h0);
      @(negedge clock);
      applyStimulus(1'b0, 3'd0, BYTE, 1'b0, 32'h0, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d_we", v),  32'(write_enable), 32'(vecs[v].exp_we));
      checkOutput($sformatf("vec%0d_err", v), 32'(error),        32'(vecs[v].exp_err));
      if (vecs[v].exp_we) begin
        checkOutput($sformatf("vec%0d_idx", v),  32'(write_index), 32'(vecs[v].idx));
        checkOutput($sformatf("vec%0d_data", v), write_data,       vecs[v].exp_data);
      end
      tick();
      checkOutput($sformatf("vec%0d_we_off", v),  32'(write_enable), 32'h0);
      checkOutput($sformatf("vec%0d_err_off", v), 32'(error),        32'h0);
    end

    // Back-to-back partial writes to ECX.
    preload(3'd2, 32'h0);
    @(negedge clock);
    applyStimulus(1'b1, 3'd2, WORD, 1'b0, 32'h00001234, 1'b0);
    tick();
    @(negedge clock);
    applyStimulus(1'b1, 3'd2, BYTE, 1'b0, 32'h000000FF, 1'b0);
    tick();
    checkOutput("ecx_first_we",   32'(write_enable), 32'h1);
    checkOutput("ecx_first_data", write_data,        32'h00001234);
    @(negedge clock);
    applyStimulus(1'b0, 3'd0, BYTE, 1'b0, 32'h0, 1'b0);
    gap = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (write_enable) begin
        gap = i;
        break;
      end
    end
    checkOutput("ecx_gap",         32'(gap),   FWD ? 32'd1 : 32'd2);
    checkOutput("ecx_second_data", write_data, 32'h000012FF);
    tick(); tick();
    checkOutput("ecx_busy_idle", 32'(busy), 32'h0);

    // Hold with a full FIFO, then release.
    seen.delete(); err_seen = 0;
    @(negedge clock);
    applyStimulus(1'b1, 3'd1, DWORD, 1'b0, 32'h00000100, 1'b1);
    tickRecord();
    @(negedge clock);
    applyStimulus(1'b1, 3'd3, DWORD, 1'b0, 32'h00000200, 1'b1);
    tickRecord();
    @(negedge clock);
    applyStimulus(1'b1, 3'd6, DWORD, 1'b0, 32'h00000300, 1'b1);
    #1;
    checkOutput("hold_ready_full", 32'(req_ready), 32'h0);
    tickRecord();
    checkOutput("hold_no_write", 32'(write_enable), 32'h0);
    @(negedge clock);
    hold = 1'b0;
    #1;
    checkOutput("hold_ready_release", 32'(req_ready), 32'h0);
    tickRecord();
    @(negedge clock);
    #1;
    checkOutput("hold_ready_after_pop", 32'(req_ready), 32'h1);
    tickRecord();
    @(negedge clock);
    applyStimulus(1'b0, 3'd0, BYTE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) tickRecord();
    checkOutput("hold_writes",  32'(seen.size()), 32'd3);
    checkOutput("hold_order0",  seen[0], 32'h00000100);
    checkOutput("hold_order1",  seen[1], 32'h00000200);
    checkOutput("hold_order2",  seen[2], 32'h00000300);
    checkOutput("hold_busy",    32'(busy), 32'h0);

    // Two illegal requests.
    seen.delete(); err_seen = 0;
    @(negedge clock);
    applyStimulus(1'b1, 3'd5, BYTE, 1'b1, 32'h00000012, 1'b0);
    tickRecord();
    @(negedge clock);
    applyStimulus(1'b1, 3'd0, ILL, 1'b0, 32'h00000034, 1'b0);
    tickRecord();
    @(negedge clock);
    applyStimulus(1'b0, 3'd0, BYTE, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) tickRecord();
    checkOutput("illegal_errors", 32'(err_seen),    32'd2);
    checkOutput("illegal_writes", 32'(seen.size()), 32'd0);
    checkOutput("illegal_busy",   32'(busy),        32'h0);

    // Reset while full and with a write in flight.
    @(negedge clock);
    applyStimulus(1'b1, 3'd0, DWORD, 1'b0, 32'hAAAA0000, 1'b1);
    tick();
    @(negedge clock);
    applyStimulus(1'b1, 3'd1, DWORD, 1'b0, 32'hBBBB0000, 1'b1);
    tick();
    @(negedge clock);
    applyStimulus(1'b0, 3'd0, BYTE, 1'b0, 32'h0, 1'b1);
    #1;
    checkOutput("rst_full_ready", 32'(req_ready), 32'h0);
    @(negedge clock);
    hold = 1'b0;
    tick();
    checkOutput("rst_inflight_we", 32'(write_enable), 32'h1);
    @(negedge clock);
    reset = 1'b1;
    tick();
    checkOutput("rst_we",    32'(write_enable), 32'h0);
    checkOutput("rst_idx",   32'(write_index),  32'h0);
    checkOutput("rst_data",  write_data,        32'h0);
    checkOutput("rst_err",   32'(error),        32'h0);
    checkOutput("rst_busy",  32'(busy),         32'h0);
    checkOutput("rst_ready", 32'(req_ready),    32'h1);
    @(negedge clock);
    reset = 1'b0;
    seen.delete(); err_seen = 0;
    for (int i = 0; i < 6; i++) tickRecord();
    checkOutput("rst_no_writes", 32'(seen.size()), 32'd0);
    checkOutput("rst_no_errors", 32'(err_seen),    32'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 8; i++) begin
      arch[i] = $urandom;
      preload(3'(i), arch[i]);
    end
    m_we = 1'b0; m_err = 1'b0; m_idx = '0; m_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clock);
      r.idx  = 3'($urandom_range(0, 7));
      r.size = 2'($urandom_range(0, 3));
      r.high = 1'($urandom_range(0, 1));
      r.data = $urandom;
      if (cyc < 2970)
        applyStimulus(($urandom_range(0, 3) != 0), r.idx, r.size, r.high, r.data,
                      ($urandom_range(0, 7) == 0));
      else
        applyStimulus(1'b0, r.idx, r.size, r.high, r.data, 1'b0);
      #1;
      exp_ready = (mq.size() < DEPTH);
      checkOutput("rand_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("rand_busy",  32'(busy),      32'((mq.size() != 0) || m_we));
      do_pop  = (mq.size() > 0) && !hold && (FWD || !(m_we && m_idx == mq[0].idx));
      do_push = req_valid && exp_ready;
      m_err = 1'b0;
      if (do_pop) begin
        h = mq.pop_front();
        if (modelIllegal(h)) begin
          m_we  = 1'b0;
          m_err = 1'b1;
        end else begin
          m_we     = 1'b1;
          m_idx    = h.idx;
          m_data   = modelMerge(arch[h.idx], h);
          arch[h.idx] = m_data;
        end
      end else begin
        m_we = 1'b0;
      end
      if (do_push) mq.push_back(r);
      tick();
      checkOutput("rand_we",   32'(write_enable), 32'(m_we));
      checkOutput("rand_err",  32'(error),        32'(m_err));
      checkOutput("rand_idx",  32'(write_index),  32'(m_idx));
      checkOutput("rand_data", write_data,        m_data);
    end
    checkOutput("rand_drained", 32'(mq.size()), 32'd0);
    checkOutput("rand_busy_end", 32'(busy),     32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
